// File: rtl/fetch_unit.sv
// Natalius fetch stage: 11-bit PC register driving the instruction ROM address, plus a hardware return stack.
// Optional overflow/underflow protection is enabled by defining FETCH_STACK_CHECK_EN.
module fetch_unit #(
   parameter logic [10:0] RESET_VECTOR = 11'd0,
   parameter int          STACK_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_en,
   input  logic        jump,
   input  logic        call,
   input  logic        ret,
   input  logic [10:0] target,
   output logic [10:0] address,
   output logic        stack_empty,
   output logic        stack_full,
   output logic        stack_ovf,
   output logic        stack_unf
);

   localparam int IW = $clog2(STACK_DEPTH);
`ifdef FETCH_STACK_CHECK_EN
   // One extra bit so the pointer can represent a completely full stack.
   localparam int SPW = IW + 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
`else
   localparam int SPW = IW;
`endif
   localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

   logic [10:0]    pc;
   logic [10:0]    next_pc;
   logic [10:0]    ret_addr;
   logic [SPW-1:0] sp;
   logic [SPW-1:0] next_sp;
   logic [SPW-1:0] sp_dec;
   logic [SPW-1:0] sp_inc;
   logic [IW-1:0]  push_idx;
   logic [IW-1:0]  pop_idx;
   logic           push;
   logic [10:0]    stack [STACK_DEPTH];

   assign ret_addr = pc + 11'd1;
   assign sp_dec   = sp - SP_ONE;
   assign sp_inc   = sp + SP_ONE;
   assign push_idx = sp[IW-1:0];
   assign pop_idx  = sp_dec[IW-1:0];

`ifdef FETCH_STACK_CHECK_EN
   logic ovf;
   logic unf;
   logic ovf_set;
   logic unf_set;

   // Next-state selection with ret > call > jump > increment priority, fault-protected.
   always_comb begin
      next_pc = pc;
      next_sp = sp;
      push    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (pc_en) begin
         if (ret) begin
            if (sp != SP_ZERO) begin
               next_pc = stack[pop_idx];
               next_sp = sp_dec;
            end else begin
               next_pc = RESET_VECTOR;
               unf_set = 1'b1;
            end
         end else if (call) begin
            next_pc = target;
            if (sp != SP_FULL) begin
               push    = 1'b1;
               next_sp = sp_inc;
            end else begin
               ovf_set = 1'b1;
            end
         end else if (jump) begin
            next_pc = target;
         end else begin
            next_pc = ret_addr;
         end
      end else begin
         next_pc = pc;
      end
   end

   // Sticky fault flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= ovf | ovf_set;
         unf <= unf | unf_set;
      end
   end

   assign stack_full = (sp == SP_FULL);
   assign stack_ovf  = ovf;
   assign stack_unf  = unf;
`else
   // Next-state selection with ret > call > jump > increment priority; pointer wraps freely.
   always_comb begin
      next_pc = pc;
      next_sp = sp;
      push    = 1'b0;
      if (pc_en) begin
         if (ret) begin
            next_pc = stack[pop_idx];
            next_sp = sp_dec;
         end else if (call) begin
            next_pc = target;
            push    = 1'b1;
            next_sp = sp_inc;
         end else if (jump) begin
            next_pc = target;
         end else begin
            next_pc = ret_addr;
         end
      end else begin
         next_pc = pc;
      end
   end

   assign stack_full = 1'b0;
   assign stack_ovf  = 1'b0;
   assign stack_unf  = 1'b0;
`endif

   // PC and stack pointer registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc <= RESET_VECTOR;
         sp <= SP_ZERO;
      end else begin
         pc <= next_pc;
         sp <= next_sp;
      end
   end

   // Return-address storage; contents are not reset, and reset suppresses a pending push.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         stack[push_idx] <= ret_addr;
      end
   end

   assign address     = pc;
   assign stack_empty = (sp == SP_ZERO);

endmodule
